// File: rtl/alm_pkg.sv
// Shared constants and state encoding for the ALM dot-product accumulator.
package alm_pkg;

  localparam int unsigned P_W         = 17;
  localparam int unsigned ACC_W_DEF   = 24;
  localparam int unsigned MAX_LEN_DEF = 256;
  localparam int unsigned CNT_W       = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/alm_sat_add.sv
// Sign-extends a product, adds it to the accumulator and clamps to the signed ACC_W range.
module alm_sat_add
  import alm_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [P_W-1:0]   p,
  output logic [ACC_W-1:0] sum,
  output logic             clamp
);

  localparam int unsigned EXT_W = ACC_W + 1;

  logic [EXT_W-1:0] raw_c;

  // One guard bit: the top two bits disagree exactly when the true sum leaves the range.
  always_comb begin
    raw_c = {acc[ACC_W-1], acc} + {{(EXT_W-P_W){p[P_W-1]}}, p};
    clamp = raw_c[EXT_W-1] ^ raw_c[EXT_W-2];
    sum   = raw_c[ACC_W-1:0];
    if (clamp) begin
      if (raw_c[EXT_W-1]) begin
        sum = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sum = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/alm_dot_acc.sv
// Packetised saturating accumulator of ALM products with a held, handshaked result.
module alm_dot_acc
  import alm_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P_W-1:0]   in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] sum_c;
  logic             clamp_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             accept_c;
  logic             at_max_c;
  logic             close_c;

  alm_sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc   (acc),
    .p     (in_p),
    .sum   (sum_c),
    .clamp (clamp_c)
  );

  assign accept_c  = in_valid && in_ready;
  assign cnt_inc_c = cnt + CNT_W'(1);
  assign at_max_c  = (cnt_inc_c == CNT_W'(MAX_LEN));
  assign close_c   = in_last || at_max_c;

  // in_ready mirrors "not HOLD" but is kept as its own flop so it is a clean registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
      out_trunc <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept_c) begin
            acc <= sum_c;
            cnt <= cnt_inc_c;
            ovf <= ovf | clamp_c;
            if (close_c) begin
              state     <= ST_HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= sum_c;
              out_count <= cnt_inc_c;
              out_ovf   <= ovf | clamp_c;
              out_trunc <= at_max_c && !in_last;
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
